// File: rtl/rx_word_align_pkg.sv
// Shared types and constants for the RX word aligner: FSM state encoding,
// default training word and counter-width helpers.
package rx_word_align_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        CHECK  = 3'd2,
        SLIP   = 3'd3,
        LOCKED = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam int              DEFAULT_DATA_WIDTH    = 8;
    localparam logic [7:0]      DEFAULT_TRAIN_PATTERN = 8'h1E;
    localparam int              DEFAULT_SLIP_WAIT_CNT = 8;
    localparam int              DEFAULT_MATCH_CNT     = 16;

    // Bits needed to hold values 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int slip_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/rx_word_align_match.sv
// Combinational training-word compare plus saturating consecutive-match counter.
module rx_word_align_match
    import rx_word_align_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int                    MATCH_CNT     = DEFAULT_MATCH_CNT,
    parameter int                    MATCH_W       = cnt_width(MATCH_CNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  is_match,
    output logic                  final_match
);

    logic [MATCH_W-1:0] match_cnt_reg;

    assign is_match    = (rx_data == TRAIN_PATTERN);
    // High on the compare that brings the run to MATCH_CNT.
    assign final_match = enable && is_match && (match_cnt_reg == MATCH_W'(MATCH_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_reg <= '0;
        end else if (clear) begin
            match_cnt_reg <= '0;
        end else if (enable) begin
            if (!is_match)
                match_cnt_reg <= '0;
            else if (match_cnt_reg != MATCH_W'(MATCH_CNT))
                match_cnt_reg <= match_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/rx_word_align.sv
// Word aligner: waits for clock alignment, then bit-slips the deserialiser
// until the training word is seen MATCH_CNT times in a row.
module rx_word_align
    import rx_word_align_pkg::*;
#(
    parameter int                    DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
    parameter int                    SLIP_WAIT_CNT = DEFAULT_SLIP_WAIT_CNT,
    parameter int                    MATCH_CNT     = DEFAULT_MATCH_CNT
) (
    input  logic                              SCLK,
    input  logic                              RESETN,
    input  logic                              CLK_ALIGN_DONE,
    input  logic                              ALIGN_RESTART,
    input  logic [DATA_WIDTH-1:0]             RX_DATA,
    output logic                              BITSLIP,
    output logic                              ALIGN_DONE,
    output logic                              ALIGN_ERR,
    output logic [$clog2(DATA_WIDTH):0]       SLIP_COUNT
);

    localparam int WAIT_W  = cnt_width(SLIP_WAIT_CNT - 1);
    localparam int SLIP_W  = slip_width(DATA_WIDTH);
    localparam int MATCH_W = cnt_width(MATCH_CNT);

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [SLIP_W-1:0]   slip_count_reg, slip_count_next;
    logic                bitslip_reg, bitslip_next;
    logic                align_done_reg, align_done_next;
    logic                align_err_reg, align_err_next;
    logic                force_idle;
    logic                is_match;
    logic                final_match;

    // Restart and loss of clock alignment both abandon the attempt outright.
    assign force_idle = ALIGN_RESTART || (!CLK_ALIGN_DONE && state_reg != IDLE);

    rx_word_align_match #(
        .DATA_WIDTH   (DATA_WIDTH),
        .TRAIN_PATTERN(TRAIN_PATTERN),
        .MATCH_CNT    (MATCH_CNT),
        .MATCH_W      (MATCH_W)
    ) u_match (
        .clk        (SCLK),
        .rst_n      (RESETN),
        .clear      (force_idle),
        .enable     (state_reg == CHECK),
        .rx_data    (RX_DATA),
        .is_match   (is_match),
        .final_match(final_match)
    );

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg      <= IDLE;
            wait_cnt_reg   <= '0;
            slip_count_reg <= '0;
            bitslip_reg    <= 1'b0;
            align_done_reg <= 1'b0;
            align_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            slip_count_reg <= slip_count_next;
            bitslip_reg    <= bitslip_next;
            align_done_reg <= align_done_next;
            align_err_reg  <= align_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (force_idle) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (CLK_ALIGN_DONE) state_next = SETTLE;
                SETTLE:  if (wait_cnt_reg == '0) state_next = CHECK;
                CHECK: begin
                    if (final_match)
                        state_next = LOCKED;
                    else if (!is_match)
                        state_next = (slip_count_reg < SLIP_W'(DATA_WIDTH - 1)) ? SLIP : ERROR;
                end
                SLIP:    state_next = SETTLE;
                LOCKED:  state_next = LOCKED;
                ERROR:   state_next = ERROR;
                default: state_next = IDLE;
            endcase
        end
    end

    // Next values for the registered outputs and counters.
    always_comb begin
        wait_cnt_next   = wait_cnt_reg;
        slip_count_next = slip_count_reg;
        if (force_idle) begin
            wait_cnt_next   = '0;
            slip_count_next = '0;
        end else begin
            case (state_reg)
                IDLE:    if (CLK_ALIGN_DONE) wait_cnt_next = WAIT_W'(SLIP_WAIT_CNT - 1);
                SETTLE:  if (wait_cnt_reg != '0) wait_cnt_next = wait_cnt_reg - 1'b1;
                CHECK:   if (state_next == SLIP) slip_count_next = slip_count_reg + 1'b1;
                SLIP:    wait_cnt_next = WAIT_W'(SLIP_WAIT_CNT - 1);
                default: ;
            endcase
        end
        bitslip_next    = (state_next == SLIP);
        align_done_next = (state_next == LOCKED);
        align_err_next  = (state_next == ERROR);
    end

    assign BITSLIP    = bitslip_reg;
    assign ALIGN_DONE = align_done_reg;
    assign ALIGN_ERR  = align_err_reg;
    assign SLIP_COUNT = slip_count_reg;

endmodule
